spi_slave_gen2: RTL and testbench

//  Parametrised SPI slave, successor to the fixed 8-bit mode-0 slave. Supports configurable word

---
 rtl/spi_slave_gen2.sv | 175 +++++++++++++++++
 tb/tb_spi_slave_gen2.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_gen2.sv
// Parametrised SPI slave: any CPOL/CPHA, MSB/LSB first, TX holding register, RX word strobe.
// Define SPI_SLAVE_RX_ACK_EN to add i_rx_ready/o_rx_overrun backpressure on the received word.
//
// state     | meaning
// WAIT_IDLE | after reset; waits for CSn high so a frame already in flight is ignored
// IDLE      | CSn high, no frame
// ACTIVE    | CSn low, shifting words
module spi_slave_gen2 #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_s_sck,
  input  logic              i_spi_s_cs_n,
  input  logic              i_spi_s_mosi,
  output logic              o_spi_s_miso,
  output logic              o_spi_s_miso_oe,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic              o_tx_underrun,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
`ifdef SPI_SLAVE_RX_ACK_EN
  input  logic              i_rx_ready,
  output logic              o_rx_overrun,
`endif
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic SCK_IDLE = (CPOL != 0);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic [1:0]             flush_cnt;
  logic                   sck_new, sck_old, cs_n_s, mosi_s;
  logic                   lead_edge, trail_edge, active, sample_edge, drive_edge;
  logic                   frame_start, word_done, load, tx_accept;

  logic [DATA_W-1:0] hold, tx_shift, tx_shifted, rx_shift, rx_next;
  logic              hold_full, tx_top, miso_q, und_pend;
  logic [CNT_W-1:0]  bit_cnt;

  // Stage 0 takes the pin; the last two stages feed edge detection and levels.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      flush_cnt <= 2'(SYNC_STAGES);
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_spi_s_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_s_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_s_mosi};
      if (flush_cnt != 2'd0) flush_cnt <= flush_cnt - 2'd1;
    end
  end

  assign sck_new    = sck_sync[SYNC_STAGES-2];
  assign sck_old    = sck_sync[SYNC_STAGES-1];
  assign cs_n_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign lead_edge  = (sck_old == SCK_IDLE) && (sck_new != SCK_IDLE);
  assign trail_edge = (sck_old != SCK_IDLE) && (sck_new == SCK_IDLE);

  assign active      = (state == ACTIVE) && !cs_n_s;
  assign sample_edge = active && ((CPHA != 0) ? trail_edge : lead_edge);
  assign drive_edge  = active && ((CPHA != 0) ? lead_edge : trail_edge);
  assign frame_start = (state == IDLE) && !cs_n_s;
  assign word_done   = sample_edge && (bit_cnt == LAST_BIT);
  assign load        = frame_start || word_done;
  assign tx_accept   = i_tx_valid && !hold_full;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= WAIT_IDLE;
    else          state <= state_nxt;
  end

  // The flush count keeps the reset values of the CSn synchroniser from looking like an idle bus.
  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_IDLE: if ((flush_cnt == 2'd0) && cs_n_s) state_nxt = IDLE;
      IDLE:      if (!cs_n_s) state_nxt = ACTIVE;
      ACTIVE:    if (cs_n_s) state_nxt = IDLE;
      default:   state_nxt = WAIT_IDLE;
    endcase
  end

  assign tx_top     = (MSB_FIRST != 0) ? tx_shift[DATA_W-1] : tx_shift[0];
  assign tx_shifted = (MSB_FIRST != 0) ? {tx_shift[DATA_W-2:0], 1'b0}
                                       : {1'b0, tx_shift[DATA_W-1:1]};
  assign rx_next    = (MSB_FIRST != 0) ? {rx_shift[DATA_W-2:0], mosi_s}
                                       : {mosi_s, rx_shift[DATA_W-1:1]};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hold          <= '0;
      hold_full     <= 1'b0;
      tx_shift      <= '0;
      miso_q        <= 1'b0;
      und_pend      <= 1'b0;
      o_tx_underrun <= 1'b0;
    end else begin
      o_tx_underrun <= 1'b0;
      if (tx_accept) begin
        hold      <= i_tx_data;
        hold_full <= 1'b1;
      end
      if (load) begin
        if (hold_full) begin
          tx_shift  <= hold;
          hold_full <= 1'b0;
        end else begin
          tx_shift <= '0;
          if (frame_start) o_tx_underrun <= 1'b1;
        end
      end else if (drive_edge && ((CPHA != 0) || (bit_cnt != '0))) begin
        // CPHA=0: the trailing edge right after a word boundary must not shift the fresh word
        tx_shift <= tx_shifted;
      end
      if (frame_start) miso_q <= 1'b0;
      else if (drive_edge && (CPHA != 0)) miso_q <= tx_top;
      // An empty reload mid-frame only counts as underrun once the master starts that word
      if (!active) und_pend <= 1'b0;
      else if (word_done && !hold_full) und_pend <= 1'b1;
      else if (und_pend && lead_edge) begin
        und_pend      <= 1'b0;
        o_tx_underrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
`ifdef SPI_SLAVE_RX_ACK_EN
      o_rx_overrun <= 1'b0;
`endif
    end else begin
      if (!active) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (sample_edge) begin
        bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
        rx_shift <= rx_next;
      end
      if (word_done) o_rx_data <= rx_next;
`ifdef SPI_SLAVE_RX_ACK_EN
      if (word_done) o_rx_valid <= 1'b1;
      else if (i_rx_ready) o_rx_valid <= 1'b0;
      o_rx_overrun <= word_done && o_rx_valid && !i_rx_ready;
`else
      o_rx_valid <= word_done;
`endif
    end
  end

  assign o_tx_ready      = !hold_full;
  assign o_busy          = (state == ACTIVE);
  assign o_spi_s_miso_oe = (state == ACTIVE);
  assign o_spi_s_miso    = (state == ACTIVE) && ((CPHA != 0) ? miso_q : tx_top);

endmodule

// File: tb/tb_spi_slave_gen2.sv
// Bench for spi_slave_gen2: mode-0/8-bit/MSB and mode-3/16-bit/LSB instances driven by a task-level
// SPI master; received words are checked by a queue-based monitor, MISO words and underruns per frame.
module tb_spi_slave_gen2;
  localparam int H = 8;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_n, rx_rdy;
  logic        sck0, cs0, mosi0, miso0, oe0, txv0, rdy0, und0, rxv0, busy0;
  logic [7:0]  txd0, rxd0;
  logic        sck1, cs1, mosi1, miso1, oe1, txv1, rdy1, und1, rxv1, busy1;
  logic [15:0] txd1, rxd1;
`ifdef SPI_SLAVE_RX_ACK_EN
  logic        ovr0, ovr1;
  int          ovr_cnt0 = 0, ovr_cnt1 = 0;
`endif

  int n_cmp = 0, n_err = 0;
  int und_cnt0 = 0, und_cnt1 = 0;
  logic [31:0] rxq0[$], rxq1[$];
  logic [31:0] f_mw[4], f_tw[4];
  bit          f_prov[4];

  spi_slave_gen2 #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_spi_s_sck(sck0), .i_spi_s_cs_n(cs0), .i_spi_s_mosi(mosi0),
    .o_spi_s_miso(miso0), .o_spi_s_miso_oe(oe0),
    .i_tx_data(txd0), .i_tx_valid(txv0), .o_tx_ready(rdy0), .o_tx_underrun(und0),
    .o_rx_data(rxd0), .o_rx_valid(rxv0),
`ifdef SPI_SLAVE_RX_ACK_EN
    .i_rx_ready(rx_rdy), .o_rx_overrun(ovr0),
`endif
    .o_busy(busy0));

  spi_slave_gen2 #(.DATA_W(16), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(3)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_spi_s_sck(sck1), .i_spi_s_cs_n(cs1), .i_spi_s_mosi(mosi1),
    .o_spi_s_miso(miso1), .o_spi_s_miso_oe(oe1),
    .i_tx_data(txd1), .i_tx_valid(txv1), .o_tx_ready(rdy1), .o_tx_underrun(und1),
    .o_rx_data(rxd1), .o_rx_valid(rxv1),
`ifdef SPI_SLAVE_RX_ACK_EN
    .i_rx_ready(rx_rdy), .o_rx_overrun(ovr1),
`endif
    .o_busy(busy1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sck(input int sel, input logic v);
    if (sel == 0) sck0 = v; else sck1 = v;
  endtask
  task automatic set_cs(input int sel, input logic v);
    if (sel == 0) cs0 = v; else cs1 = v;
  endtask
  task automatic set_mosi(input int sel, input logic v);
    if (sel == 0) mosi0 = v; else mosi1 = v;
  endtask
  function automatic logic get_miso(input int sel); return (sel == 0) ? miso0 : miso1; endfunction
  function automatic logic get_oe(input int sel);   return (sel == 0) ? oe0 : oe1;     endfunction
  function automatic logic get_busy(input int sel); return (sel == 0) ? busy0 : busy1; endfunction
  function automatic logic get_rdy(input int sel);  return (sel == 0) ? rdy0 : rdy1;   endfunction

  task automatic push_rx(input int sel, input logic [31:0] v);
    if (sel == 0) rxq0.push_back(v); else rxq1.push_back(v);
  endtask

  // Pops the expected word on every accepted RX strobe and counts single-cycle pulses.
  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rxv0 && rx_rdy) begin
        if (rxq0.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL m0_rx_unexpected: got word 0x%0h, expected no word", rxd0);
        end else begin
          e = rxq0.pop_front();
          check("m0_rx_word", 32'(rxd0), e);
        end
      end
      if (rxv1 && rx_rdy) begin
        if (rxq1.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL m3_rx_unexpected: got word 0x%0h, expected no word", rxd1);
        end else begin
          e = rxq1.pop_front();
          check("m3_rx_word", 32'(rxd1), e);
        end
      end
      if (und0) und_cnt0++;
      if (und1) und_cnt1++;
`ifdef SPI_SLAVE_RX_ACK_EN
      if (ovr0) ovr_cnt0++;
      if (ovr1) ovr_cnt1++;
`endif
    end
  endtask

  task automatic tx_write(input int sel, input logic [31:0] d);
    check(sel ? "m3_tx_ready_before_write" : "m0_tx_ready_before_write", 32'(get_rdy(sel)), 1);
    if (sel == 0) begin txd0 = d[7:0]; txv0 = 1'b1; end
    else begin txd1 = d[15:0]; txv1 = 1'b1; end
    tick(1);
    txv0 = 1'b0;
    txv1 = 1'b0;
    check(sel ? "m3_tx_ready_after_write" : "m0_tx_ready_after_write", 32'(get_rdy(sel)), 0);
  endtask

  // Half SCK period; the next word is offered during bit 1 of the current one when requested.
  task automatic half_wait(input int sel, input int i, input int j, input int nw);
    if (i == 1 && j + 1 < nw && f_prov[j+1]) begin
      tx_write(sel, f_tw[j+1]);
      tick(H - 1);
    end else begin
      tick(H);
    end
  endtask

  // One CS frame of nw words; a nonzero cut ends the last word after that many bits.
  task automatic run_frame(input int sel, input int nw, input int cut, input bit push);
    int w, nb, b, exp_und, und_start, und_now;
    bit cpol, cpha, msb;
    logic [31:0] got, exp_word;
    string pfx;
    w = sel ? 16 : 8;
    cpol = (sel != 0);
    cpha = (sel != 0);
    msb = (sel == 0);
    pfx = sel ? "m3_" : "m0_";
    exp_und = 0;
    for (int j = 0; j < nw; j++) begin
      if (!f_prov[j]) exp_und++;
      if (push && !(cut > 0 && j == nw - 1)) push_rx(sel, f_mw[j]);
    end
    und_start = sel ? und_cnt1 : und_cnt0;
    if (f_prov[0]) tx_write(sel, f_tw[0]);
    set_cs(sel, 1'b0);
    tick(H);
    check({pfx, "miso_oe_active"}, 32'(get_oe(sel)), 1);
    check({pfx, "busy_active"}, 32'(get_busy(sel)), 1);
    check({pfx, "tx_ready_after_load"}, 32'(get_rdy(sel)), 1);
    for (int j = 0; j < nw; j++) begin
      got = '0;
      nb = (cut > 0 && j == nw - 1) ? cut : w;
      for (int i = 0; i < nb; i++) begin
        b = msb ? w - 1 - i : i;
        if (!cpha) begin
          set_mosi(sel, f_mw[j][b]);
          tick(H);
          set_sck(sel, !cpol);
          got[b] = get_miso(sel);
          half_wait(sel, i, j, nw);
          set_sck(sel, cpol);
        end else begin
          set_sck(sel, !cpol);
          set_mosi(sel, f_mw[j][b]);
          half_wait(sel, i, j, nw);
          set_sck(sel, cpol);
          got[b] = get_miso(sel);
          tick(H);
        end
      end
      if (nb == w) begin
        exp_word = f_prov[j] ? f_tw[j] : 32'h0;
        check({pfx, "miso_word"}, got, exp_word);
      end
    end
    tick(H);
    set_cs(sel, 1'b1);
    tick(2 * H);
    check({pfx, "miso_oe_idle"}, 32'(get_oe(sel)), 0);
    und_now = sel ? und_cnt1 : und_cnt0;
    check({pfx, "underrun_pulses"}, 32'(und_now - und_start), 32'(exp_und));
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, nw, cut, w;
    logic [31:0] mask;
    rst_n = 1'b0; rx_rdy = 1'b1;
    sck0 = 1'b0; cs0 = 1'b1; mosi0 = 1'b0; txd0 = '0; txv0 = 1'b0;
    sck1 = 1'b1; cs1 = 1'b1; mosi1 = 1'b0; txd1 = '0; txv1 = 1'b0;
    fork monitor(); join_none
    tick(3);
    check("rst_miso",      32'(miso0), 0);
    check("rst_miso_oe",   32'(oe0), 0);
    check("rst_tx_ready",  32'(rdy0), 1);
    check("rst_underrun",  32'(und0), 0);
    check("rst_rx_data",   32'(rxd0), 0);
    check("rst_rx_valid",  32'(rxv0), 0);
    check("rst_busy",      32'(busy0), 0);
    check("rst_m3_ready",  32'(rdy1), 1);
    check("rst_m3_busy",   32'(busy1), 0);
    rst_n = 1'b1;
    tick(6);

    // mode 0: preloaded 0xA5 out, 0x3C in
    f_mw[0] = 32'h3C; f_tw[0] = 32'hA5; f_prov[0] = 1;
    run_frame(0, 1, 0, 1);
    check("m0_rx_data_3c", 32'(rxd0), 32'h3C);

    // mode 3, 16-bit LSB first: two back-to-back words
    f_mw[0] = 32'h5AC3; f_mw[1] = 32'h0F71;
    f_tw[0] = 32'h1234; f_tw[1] = 32'hBEEF; f_prov[0] = 1; f_prov[1] = 1;
    run_frame(1, 2, 0, 1);
    check("m3_rx_data_last", 32'(rxd1), 32'h0F71);

    // empty holding register at CS fall
    f_mw[0] = 32'h96; f_prov[0] = 0;
    run_frame(0, 1, 0, 1);

    // CS rises after 5 bits, then a clean 0x81 frame
    f_mw[0] = 32'hE7; f_tw[0] = 32'h42; f_prov[0] = 1;
    run_frame(0, 1, 5, 1);
    f_mw[0] = 32'h81; f_tw[0] = 32'h3D; f_prov[0] = 1;
    run_frame(0, 1, 0, 1);
    check("m0_rx_data_81", 32'(rxd0), 32'h81);

    // reset during a frame, released with CSn still low
    tx_write(0, 32'h5A);
    cs0 = 1'b0; tick(H);
    for (int i = 0; i < 3; i++) begin
      mosi0 = i[0]; tick(H); sck0 = 1'b1; tick(H); sck0 = 1'b0;
    end
    rst_n = 1'b0; tick(2);
    check("rst_mid_tx_ready", 32'(rdy0), 1);
    check("rst_mid_miso_oe", 32'(oe0), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mosi0 = 1'b1; tick(H); sck0 = 1'b1; tick(H); sck0 = 1'b0;
      if (i == 2 || i == 7) begin
        check("rst_frame_ignored_oe", 32'(oe0), 0);
        check("rst_frame_ignored_busy", 32'(busy0), 0);
      end
    end
    tick(H); cs0 = 1'b1; tick(4 * H);
    f_mw[0] = 32'h81; f_tw[0] = 32'hC6; f_prov[0] = 1;
    run_frame(0, 1, 0, 1);

    // randomized frames on both instances
    for (int k = 0; k < 12; k++) begin
      sel = k % 2;
      w = sel ? 16 : 8;
      mask = (32'h1 << w) - 32'h1;
      nw = $urandom_range(1, 3);
      for (int j = 0; j < 4; j++) begin
        f_mw[j] = $urandom & mask;
        f_tw[j] = $urandom & mask;
        f_prov[j] = ($urandom_range(0, 3) != 0);
      end
      cut = ($urandom_range(0, 4) == 0) ? $urandom_range(1, w - 1) : 0;
      run_frame(sel, nw, cut, 1);
    end

`ifdef SPI_SLAVE_RX_ACK_EN
    begin
      int ovr_start;
      rx_rdy = 1'b0;
      ovr_start = ovr_cnt0;
      f_mw[0] = 32'h11; f_mw[1] = 32'h22; f_tw[0] = 32'h01; f_tw[1] = 32'h02;
      f_prov[0] = 1; f_prov[1] = 1;
      run_frame(0, 2, 0, 0);
      check("ack_rx_valid_held", 32'(rxv0), 1);
      check("ack_rx_data", 32'(rxd0), 32'h22);
      check("ack_overrun_pulses", 32'(ovr_cnt0 - ovr_start), 1);
      push_rx(0, 32'h22);
      rx_rdy = 1'b1;
      tick(3);
      check("ack_rx_valid_cleared", 32'(rxv0), 0);
    end
`endif

    tick(4 * H);
    check("m0_rx_queue_drained", 32'(rxq0.size()), 0);
    check("m3_rx_queue_drained", 32'(rxq1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
